// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The master (requester) drives start and bcd_in.
// The slave (converter) returns binary, busy, done and error.
//   start   master->slave  request a conversion
//   bcd_in  master->slave  packed BCD operand, 4*DIGITS bits, digit 0 in [3:0]
//   binary  slave->master  BIN_W-bit result, held between conversions
//   busy    slave->master  converter is iterating or presenting a result
//   done    slave->master  one-cycle pulse, binary/error valid
//   error   slave->master  invalid digit or out-of-range result
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 16
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, bcd_in,
        input  binary, busy, done, error
    );

    modport slave (
        input  start, bcd_in,
        output binary, busy, done, error
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble.
// One shift-right/correct step runs per clock, BIN_W steps per operand.
// Ports:
//   clk  single clock, all state changes on the rising edge
//   rst  asynchronous active-high reset, aborts any conversion silently
//   bus  slave side of bcd_to_bin_seq_if (start, bcd_in -> binary, busy, done, error)
module bcd_to_bin_seq #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_bin_seq_if.slave  bus
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Shift = 2'd1,
        Done  = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [4*DIGITS-1:0]   bcdWork_q, bcdWork_d;
    logic [BIN_W-1:0]      binWork_q, binWork_d;
    logic [BIN_W-1:0]      binary_q,  binary_d;
    logic                  error_q,   error_d;

    logic [4*DIGITS-1:0]   shBcd;
    logic [4*DIGITS-1:0]   corrBcd;
    logic [BIN_W-1:0]      shBin;
    logic                  anyInvalid;

    // One reverse double dabble step: the combined {bcd, bin} register
    // shifts right so the BCD LSB falls into the binary MSB, then each
    // digit that became 8 or more is brought back into BCD range by
    // subtracting 3 (the inverse of the add-3 used when going the other way).
    // Digits are corrected independently; no borrow crosses a digit.
    always_comb begin
        {shBcd, shBin} = {bcdWork_q, binWork_q} >> 1;
        corrBcd = shBcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (shBcd[4*d+3]) begin
                corrBcd[4*d +: 4] = shBcd[4*d +: 4] - 4'd3;
            end
        end
    end

    // Any incoming digit above 9 makes the operand unusable; it is flagged
    // straight away instead of spending BIN_W cycles on garbage.
    always_comb begin
        anyInvalid = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.bcd_in[4*d +: 4] > 4'd9) begin
                anyInvalid = 1'b1;
            end
        end
    end

    // Next-state logic. Idle and Done both accept a new operand, so
    // back-to-back requests lose no cycle. On the last Shift step the
    // result is published and any BCD value left in the work register
    // means the decimal number did not fit into BIN_W bits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bcdWork_d = bcdWork_q;
        binWork_d = binWork_q;
        binary_d  = binary_q;
        error_d   = error_q;

        case (state_q)
            Idle, Done: begin
                state_d = Idle;
                if (bus.start) begin
                    bcdWork_d = bus.bcd_in;
                    binWork_d = '0;
                    cnt_d     = '0;
                    if (anyInvalid) begin
                        state_d  = Done;
                        binary_d = '0;
                        error_d  = 1'b1;
                    end else begin
                        state_d = Shift;
                    end
                end
            end
            Shift: begin
                bcdWork_d = corrBcd;
                binWork_d = shBin;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d  = Done;
                    binary_d = shBin;
                    error_d  = (corrBcd != '0);
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so an aborted
    // conversion leaves no trace and produces no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= Idle;
            cnt_q     <= '0;
            bcdWork_q <= '0;
            binWork_q <= '0;
            binary_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcdWork_q <= bcdWork_d;
            binWork_q <= binWork_d;
            binary_q  <= binary_d;
            error_q   <= error_d;
        end
    end

    assign bus.busy   = (state_q != Idle);
    assign bus.done   = (state_q == Done);
    assign bus.binary = binary_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: a table of directed operands with
// hand-computed results and latencies, followed by hand-written sequences for
// back-to-back starts, start during Shift, and reset mid-conversion.
module tb_bcd_to_bin_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bcd_to_bin_seq_if #(.DIGITS(5), .BIN_W(16)) bus ();

    bcd_to_bin_seq #(.DIGITS(5), .BIN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        logic [15:0] expBin;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs [8];
    int   checkCount = 0;
    int   passCount  = 0;

    // Compare one observed value against its expected value and log a FAIL
    // line when they differ.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one operand with a single-cycle start, then count edges from
    // the accepting edge until done rises (bounded), and capture the result.
    task automatic applyStimulus(input logic [19:0] bcd, output int lat,
                                 output logic [15:0] bin, output logic err,
                                 output logic doneSeen);
        @(negedge clk);
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        doneSeen = bus.done;
        bin      = bus.binary;
        err      = bus.error;
    endtask

    initial begin
        int          lat;
        logic [15:0] bin;
        logic        err;
        logic        doneSeen;
        int          doneHits;
        int          lastHit;

        vecs[0] = '{20'h12345, 16'h3039, 1'b0, 17};
        vecs[1] = '{20'h00000, 16'h0000, 1'b0, 17};
        vecs[2] = '{20'h65535, 16'hFFFF, 1'b0, 17};
        vecs[3] = '{20'h65536, 16'h0000, 1'b1, 17};
        vecs[4] = '{20'h99999, 16'h869F, 1'b1, 17};
        vecs[5] = '{20'h0A123, 16'h0000, 1'b1, 1};
        vecs[6] = '{20'h09999, 16'h270F, 1'b0, 17};
        vecs[7] = '{20'h00042, 16'h002A, 1'b0, 17};

        bus.start  = 1'b0;
        bus.bcd_in = '0;

        #3 rst = 1'b1;
        #1;
        checkOutput("reset_busy",   32'(bus.busy),   32'h0);
        checkOutput("reset_done",   32'(bus.done),   32'h0);
        checkOutput("reset_binary", 32'(bus.binary), 32'h0);
        checkOutput("reset_error",  32'(bus.error),  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].bcd, lat, bin, err, doneSeen);
            $display("[TB] vector %0d bcd=0x%05h binary=0x%04h error=%0b latency=%0d",
                     i, vecs[i].bcd, bin, err, lat);
            checkOutput($sformatf("vec%0d_done", i),    32'(doneSeen), 32'h1);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat),      32'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d_binary", i),  32'(bin),      32'(vecs[i].expBin));
            checkOutput($sformatf("vec%0d_error", i),   32'(err),      32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_busy", i),    32'(bus.busy), 32'h1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'h0);
            checkOutput($sformatf("vec%0d_hold", i),       32'(bus.binary), 32'(vecs[i].expBin));
        end

        // Start held high: done must recur every 17 cycles with binary=42.
        @(negedge clk);
        bus.bcd_in = 20'h00042;
        bus.start  = 1'b1;
        doneHits = 0;
        lastHit  = 0;
        for (int c = 1; c <= 60 && doneHits < 3; c++) begin
            @(negedge clk);
            if (bus.done) begin
                doneHits++;
                checkOutput($sformatf("held_binary%0d", doneHits), 32'(bus.binary), 32'd42);
                checkOutput($sformatf("held_error%0d", doneHits),  32'(bus.error),  32'h0);
                if (doneHits > 1) begin
                    checkOutput($sformatf("held_period%0d", doneHits), 32'(c - lastHit), 32'd17);
                end else begin
                    checkOutput("held_first_latency", 32'(c), 32'd17);
                end
                lastHit = c;
            end
        end
        bus.start = 1'b0;
        checkOutput("held_done_count", 32'(doneHits), 32'd3);
        @(negedge clk);
        @(negedge clk);

        // A start pulse with a different operand during Shift is ignored.
        bus.bcd_in = 20'h00042;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        repeat (5) begin
            @(negedge clk);
            lat++;
        end
        bus.bcd_in = 20'h00777;
        bus.start  = 1'b1;
        @(negedge clk);
        lat++;
        bus.start  = 1'b0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("midshift_latency", 32'(lat),        32'd17);
        checkOutput("midshift_binary",  32'(bus.binary), 32'd42);
        checkOutput("midshift_error",   32'(bus.error),  32'h0);
        @(negedge clk);
        checkOutput("midshift_no_restart", 32'(bus.busy), 32'h0);

        // Reset at iteration 8 clears everything at once and drops the op.
        bus.bcd_in = 20'h12345;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy",   32'(bus.busy),   32'h0);
        checkOutput("abort_done",   32'(bus.done),   32'h0);
        checkOutput("abort_binary", 32'(bus.binary), 32'h0);
        checkOutput("abort_error",  32'(bus.error),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        doneHits = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) doneHits++;
        end
        checkOutput("abort_no_done", 32'(doneHits), 32'h0);

        applyStimulus(20'h09999, lat, bin, err, doneSeen);
        checkOutput("after_abort_done",    32'(doneSeen), 32'h1);
        checkOutput("after_abort_latency", 32'(lat),      32'd17);
        checkOutput("after_abort_binary",  32'(bin),      32'h270F);
        checkOutput("after_abort_error",   32'(err),      32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
